// File: rtl/wvb_reader_if.sv
// wvb_reader_if: bundles the read-controller request/ack channel and the
// DPRAM ready/done handoff of the waveform-buffer readout scheduler.
// master = wvb_reader side, slave = read controller / DPRAM consumer side.
interface wvb_reader_if;
  logic        rd_ctrl_req;
  logic [7:0]  rd_ctrl_idx;
  logic        rd_ctrl_dpram_mode;
  logic        rd_ctrl_ack;
  logic        rd_ctrl_more;
  logic [15:0] rd_ctrl_dpram_len;
  logic        dpram_ready;
  logic [15:0] dpram_len;
  logic        dpram_done;

  modport master (
    output rd_ctrl_req, rd_ctrl_idx, rd_ctrl_dpram_mode, dpram_ready, dpram_len,
    input  rd_ctrl_ack, rd_ctrl_more, rd_ctrl_dpram_len, dpram_done
  );

  modport slave (
    input  rd_ctrl_req, rd_ctrl_idx, rd_ctrl_dpram_mode, dpram_ready, dpram_len,
    output rd_ctrl_ack, rd_ctrl_more, rd_ctrl_dpram_len, dpram_done
  );
endinterface

// File: rtl/wvb_reader.sv
// wvb_reader: round-robin readout scheduler feeding wvb_rd_ctrl_fmt_0.
// Picks a channel with a complete waveform, requests it from the read
// controller, then hands the filled DPRAM to the consumer via ready/done.
// Continuation DPRAMs (rd_ctrl_more) re-request the same channel.
// Optional: define WVB_READER_TIMEOUT_EN to add an ack watchdog that aborts
// a stuck request after P_TIMEOUT cycles and raises sticky timeout_err.
module wvb_reader #(
  parameter int N_CHANNELS = 8,
  parameter int P_TIMEOUT  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  dpram_mode,
  input  logic [N_CHANNELS-1:0] wvb_avail,
  wvb_reader_if.master          bus,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_ACK_LOW = 2'd2,
    S_READY   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  idx_q, idx_d;
  logic        mode_q, mode_d;
  logic        req_q, req_d;
  logic        ready_q, ready_d;
  logic [15:0] len_q, len_d;
  logic        more_q, more_d;
  logic        busy_q, busy_d;
  logic        terr_q, terr_d;

  logic        sel_found;
  logic [7:0]  sel_idx;

`ifdef WVB_READER_TIMEOUT_EN
  localparam int CNT_W = $clog2(P_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  localparam int unused_timeout = P_TIMEOUT;
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  // Round-robin search: first set avail bit above ptr_q, wrapping, so the
  // channel served last has the lowest priority.
  always_comb begin : sel_search
    int j;
    j         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 1; i <= N_CHANNELS; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N_CHANNELS) j = j - N_CHANNELS;
      if (!sel_found && wvb_avail[j]) begin
        sel_found = 1'b1;
        sel_idx   = 8'(j);
      end
    end
  end

  // Next-state and registered-output logic for the scheduler FSM.
  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    req_d   = req_q;
    ready_d = ready_q;
    len_d   = len_q;
    more_d  = more_q;
    terr_d  = terr_q;

    case (state_q)
      S_IDLE: begin
        if (en && sel_found && !terr_q) begin
          idx_d   = sel_idx;
          ptr_d   = sel_idx;
          mode_d  = dpram_mode;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        req_d = 1'b1;
        // Only an ack seen while req is actually on the wire counts.
        if (req_q && bus.rd_ctrl_ack) begin
          len_d   = bus.rd_ctrl_dpram_len;
          more_d  = bus.rd_ctrl_more;
          req_d   = 1'b0;
          state_d = S_ACK_LOW;
        end
      end
      S_ACK_LOW: begin
        if (!bus.rd_ctrl_ack) begin
          ready_d = 1'b1;
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (bus.dpram_done) begin
          ready_d = 1'b0;
          len_d   = '0;
          state_d = more_q ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef WVB_READER_TIMEOUT_EN
    cnt_d = '0;
    if (err_clr) terr_d = 1'b0;
    if (state_q == S_REQ || state_q == S_ACK_LOW) begin
      cnt_d = cnt_q + 1'b1;
      // Abort after P_TIMEOUT cycles waiting; placed after err_clr so a
      // coincident timeout keeps the flag set.
      if (cnt_q == CNT_W'(P_TIMEOUT - 1)) begin
        cnt_d   = '0;
        req_d   = 1'b0;
        len_d   = '0;
        terr_d  = 1'b1;
        state_d = S_IDLE;
      end
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, async active-low reset.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 8'(N_CHANNELS - 1);
      idx_q   <= '0;
      mode_q  <= 1'b0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      len_q   <= '0;
      more_q  <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      len_q   <= len_d;
      more_q  <= more_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

`ifdef WVB_READER_TIMEOUT_EN
  // Ack watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign bus.rd_ctrl_req        = req_q;
  assign bus.rd_ctrl_idx        = idx_q;
  assign bus.rd_ctrl_dpram_mode = mode_q;
  assign bus.dpram_ready        = ready_q;
  assign bus.dpram_len          = len_q;
  assign busy                   = busy_q;
`ifdef WVB_READER_TIMEOUT_EN
  assign timeout_err            = terr_q;
`else
  assign timeout_err            = 1'b0;
`endif

endmodule
